// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if -- bundles the core-side request/response signals and the
// RAM-side port of the memory arbiter.
//   slave  : arbiter view (takes core requests and RAM responses,
//            drives waits, load data and the RAM command)
//   master : environment view (fetch stage, load/store path, RAM model)
// Signals:
//   iREN/iaddr/iload/iwait              instruction fetch requester
//   dREN/dWEN/daddr/dstore/dload/dwait  data requester
//   halt                                core halted, blocks new fetch grants
//   ram_req/ram_wen/ram_addr/ram_wdata  RAM command
//   ram_rdata/ram_ack                   RAM response
//   bus_err                             sticky access-timeout flag
interface memory_arbiter_if;
  logic        iREN;
  logic [63:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [63:0] daddr;
  logic [63:0] dstore;
  logic [63:0] dload;
  logic        dwait;
  logic        halt;
  logic        ram_req;
  logic        ram_wen;
  logic [63:0] ram_addr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;
  logic        ram_ack;
  logic        bus_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ram_rdata, ram_ack,
    output iload, iwait, dload, dwait, ram_req, ram_wen, ram_addr, ram_wdata,
           bus_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ram_rdata, ram_ack,
    input  iload, iwait, dload, dwait, ram_req, ram_wen, ram_addr, ram_wdata,
           bus_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter -- serialises instruction-fetch and data accesses onto the
// single 64-bit unified RAM port. Each access runs IDLE -> xGRANT -> xRESP;
// the requester's wait drops in the RESP cycle. The fetched 32-bit word is
// selected from the 64-bit beat by address bit 2.
// Ports:
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   memory_arbiter_if.slave (requesters + RAM port + bus_err)
// Parameters:
//   TIMEOUT  grant cycles to wait for ram_ack before aborting (0 = never)
// Build option:
//   MEMARB_RR_EN  alternate priority under contention (default: data first)
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, IGRANT, DGRANT, IRESP, DRESP} state_e;

  // Last grant cycle index before abort: the grant lasts TIMEOUT cycles.
  localparam logic [31:0] TLIM = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_e      state_q;
  logic        ram_req_q;
  logic        ram_wen_q;
  logic [63:0] ram_addr_q;
  logic [63:0] ram_wdata_q;
  logic [63:0] rdata_q;
  logic        isel_q;
  logic        bus_err_q;
  logic [31:0] tcnt_q;
`ifdef MEMARB_RR_EN
  logic        last_d_q;  // 1: data won the last grant
`endif

  logic d_pend;
  logic i_pend;
  logic pick_d;
  logic timed_out;

  assign d_pend    = bus.dREN | bus.dWEN;
  assign i_pend    = bus.iREN & ~bus.halt;
  assign timed_out = (TIMEOUT != 0) && (tcnt_q == TLIM);

`ifdef MEMARB_RR_EN
  // Under contention the requester that did not win last time goes first.
  assign pick_d = d_pend & (~i_pend | ~last_d_q);
`else
  assign pick_d = d_pend;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      isel_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      tcnt_q      <= '0;
`ifdef MEMARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tcnt_q <= '0;
          if (pick_d) begin
            state_q     <= DGRANT;
            ram_req_q   <= 1'b1;
            ram_wen_q   <= bus.dWEN;
            ram_addr_q  <= bus.daddr;
            ram_wdata_q <= bus.dstore;
`ifdef MEMARB_RR_EN
            last_d_q    <= 1'b1;
`endif
          end else if (i_pend) begin
            state_q    <= IGRANT;
            ram_req_q  <= 1'b1;
            ram_wen_q  <= 1'b0;
            ram_addr_q <= bus.iaddr;
            isel_q     <= bus.iaddr[2];
`ifdef MEMARB_RR_EN
            last_d_q   <= 1'b0;
`endif
          end
        end
        IGRANT, DGRANT: begin
          // A dropped request does not abort: the access still completes.
          if (bus.ram_ack) begin
            rdata_q   <= bus.ram_rdata;
            ram_req_q <= 1'b0;
            ram_wen_q <= 1'b0;
            state_q   <= (state_q == IGRANT) ? IRESP : DRESP;
          end else if (timed_out) begin
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
            ram_req_q <= 1'b0;
            ram_wen_q <= 1'b0;
            state_q   <= (state_q == IGRANT) ? IRESP : DRESP;
          end else begin
            tcnt_q <= tcnt_q + 32'd1;
          end
        end
        IRESP, DRESP: state_q <= IDLE;
        default:      state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_req   = ram_req_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.iload     = isel_q ? rdata_q[63:32] : rdata_q[31:0];
  assign bus.dload     = rdata_q;
  assign bus.iwait     = bus.iREN & (state_q != IRESP);
  assign bus.dwait     = d_pend & (state_q != DRESP);
  assign bus.bus_err   = bus_err_q;

endmodule
